instr_cache_responder: RTL
==========================

# instr_cache_responder

Stalling instruction-memory responder that serves the fetch stage's `Addr`/`Rd`/`Wr` requests and drives `DataOut`/`Stall`/`Done`/`CacheHit`/`err` back to it. It sits between fetch and a slower backing memory, and holds a direct-mapped, one-word-per-line cache. Hits complete combinationally in the request cycle. Misses and writes stall fetch until the backing memory acknowledges.

## Interface
- `INDEX_BITS`, default 4: cache has 2^INDEX_BITS lines of one 16-bit word each. Legal range is 1..8.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `Addr` input 16: byte address of the request; word index is `Addr[15:1]`.
- `DataIn` input 16: write data.
- `Rd` input 1: read request.
- `Wr` input 1: write request.
- `createdump` input 1: flush request; invalidates all lines.
- `DataOut` output 16: read data, valid when `Done`=1.
- `Stall` output 1: request accepted but not complete; the requester must hold `Addr`, `Rd`, `Wr` and `DataIn` stable.
- `Done` output 1: request completes this cycle.
- `CacheHit` output 1: the completing read was served from the cache.
- `err` output 1: misaligned or illegal request.
- `mem_addr` output 16: backing-memory word address, `{Addr[15:1],1'b0}`.
- `mem_rd` output 1: backing-memory read strobe, held until `mem_ready`.
- `mem_wr` output 1: backing-memory write strobe, held until `mem_ready`.
- `mem_wdata` output 16: backing-memory write data, equal to `DataIn`.
- `mem_rdata` input 16: backing-memory read data, valid with `mem_ready`.
- `mem_ready` input 1: backing-memory completion, one-cycle pulse.

## Operation
- Line index is `Addr[INDEX_BITS:1]`. Tag is `Addr[15:INDEX_BITS+1]`.
- Each line stores a valid bit, a tag and a 16-bit data word.
- Illegal request is `(Rd|Wr) & (Addr[0] | (Rd&Wr))`. On an illegal request:
  - `err`=1 combinationally.
  - `Stall`=`Done`=`CacheHit`=0.
  - No state change.
- The FSM has four states: IDLE, RD_MISS, WR_THRU and COMPLETE.
- **IDLE**
  - Read hit: `DataOut`=line data, `Done`=1, `CacheHit`=1, `Stall`=0. Stay in IDLE.
  - Read miss: `Stall`=1, go to RD_MISS.
  - Write (hit or miss): `Stall`=1, go to WR_THRU.
  - `createdump`=1 with no legal request: clear all valid bits at the clock edge.
  - No request: all strobes are 0.
- **RD_MISS**
  - Drives `mem_rd`=1 and `Stall`=1.
  - On `mem_ready`: write tag, data and valid=1 into the line; latch `mem_rdata` into the fill register; go to COMPLETE.
- **WR_THRU**
  - Drives `mem_wr`=1 and `Stall`=1.
  - On `mem_ready`: if the tag matches and the line is valid, update the line data with `DataIn` (write-through, no-allocate); go to COMPLETE.
- **COMPLETE**
  - `Done`=1, `Stall`=0, `CacheHit`=0.
  - `DataOut` = fill register after a read; `DataOut` = 0 after a write.
  - Always returns to IDLE.
  - A new request is not evaluated in COMPLETE; it is evaluated in the following IDLE cycle.
- `createdump` while not in IDLE is ignored.
- `DataOut` is 0 whenever `Done`=0.

## Timing
- Reset values:
  - State IDLE, all valid bits 0, fill register 0.
  - `DataOut`=0, `Stall`=0, `Done`=0, `CacheHit`=0, `err`=0.
  - `mem_rd`=0, `mem_wr`=0.
- Hit latency is 0 cycles: `Done` in the same cycle as `Rd`.
- Miss latency is L+1 cycles, where L is the number of cycles from `mem_rd` assertion to `mem_ready`:
  - `Stall` is high from the request cycle through the `mem_ready` cycle.
  - `Done` is high the cycle after `mem_ready`.
- `Stall` and `Done` are never both 1.
- `mem_rd` and `mem_wr` are never both 1.
- `mem_ready` outside RD_MISS or WR_THRU is ignored.
- Reset mid-miss:
  - At the reset edge, the FSM returns to IDLE and all valid bits clear; nothing is written into the cache.
  - `mem_rd` is 0 from the next cycle.
  - A `mem_ready` arriving while `rst`=1 is ignored.
- Two addresses that differ only in tag map to the same line. The later fill overwrites the earlier one.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds outputs `hit_count` [15:0] and `miss_count` [15:0].
  - `hit_count` increments on each IDLE read hit; `miss_count` increments on each IDLE to RD_MISS transition.
  - Both saturate at 16'hFFFF and reset to 0.
  - `createdump` does not clear them.
- `ICACHE_STATS_EN` undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
- Cold read miss:
  - Stimulus: after reset, `Rd`=1, `Addr`=16'h0010; `mem_ready` pulses 3 cycles after `mem_rd` rises with `mem_rdata`=16'hA5A5.
  - Response: `Stall`=1 for 4 cycles, then `Done`=1, `CacheHit`=0, `DataOut`=16'hA5A5.
- Hit after fill: re-read 16'h0010 in the next IDLE cycle -> same cycle `Done`=1, `CacheHit`=1, `DataOut`=16'hA5A5, `mem_rd`=0.
- Conflict eviction:
  - Stimulus: with `INDEX_BITS`=4, fill 16'h0010, then read 16'h0030 (same index, different tag), then read 16'h0010 again.
  - Response: both later reads miss; `miss_count`=3 with `ICACHE_STATS_EN` defined.
- Write-through:
  - Stimulus: with 16'h0010 cached, `Wr`=1, `DataIn`=16'h1234; `mem_ready` pulses after 2 cycles.
  - Response: `mem_wr`=1 with `mem_wdata`=16'h1234 for 2 cycles, then `Done`; a subsequent read hits with `DataOut`=16'h1234.
- Errors:
  - `Rd`=1, `Addr`=16'h0011 -> `err`=1, `Stall`=`Done`=0, no `mem_rd`.
  - `Rd`=`Wr`=1 -> `err`=1.
- Reset and flush:
  - `rst` pulsed during RD_MISS, then `mem_ready` -> no `Done`; a re-read of the same address misses.
  - `createdump`=1 in IDLE -> the next read of a cached address misses.

Source files
------------

// File: rtl/instr_cache_responder.sv
// Stalling instruction-memory responder with a direct-mapped, one-word-per-line cache.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module instr_cache_responder #(
   parameter int INDEX_BITS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] Addr,
   input  logic [15:0] DataIn,
   input  logic        Rd,
   input  logic        Wr,
   input  logic        createdump,
   output logic [15:0] DataOut,
   output logic        Stall,
   output logic        Done,
   output logic        CacheHit,
   output logic        err,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready
`ifdef ICACHE_STATS_EN
   ,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
`endif
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 15 - INDEX_BITS;

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_RD_MISS  = 2'd1;
   localparam logic [1:0] S_WR_THRU  = 2'd2;
   localparam logic [1:0] S_COMPLETE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [TAG_W-1:0] tag_d  [LINES];
   logic [15:0]      data_q [LINES];
   logic [15:0]      data_d [LINES];
   logic [15:0]      fill_q, fill_d;
   logic             rd_op_q, rd_op_d;

   logic [INDEX_BITS-1:0] idx_s;
   logic [TAG_W-1:0]      tag_s;
   logic                  illegal_s;
   logic                  line_hit_s;
   logic                  legal_rd_s;

   assign idx_s      = Addr[INDEX_BITS:1];
   assign tag_s      = Addr[15:INDEX_BITS+1];
   assign illegal_s  = (Rd | Wr) & (Addr[0] | (Rd & Wr));
   assign line_hit_s = valid_q[idx_s] & (tag_q[idx_s] == tag_s);
   assign legal_rd_s = (state_q == S_IDLE) & Rd & ~illegal_s;
   assign mem_addr   = {Addr[15:1], 1'b0};
   assign mem_wdata  = DataIn;

   // Next-state, cache update and fetch-side response decode.
   always_comb begin
      state_d  = state_q;
      valid_d  = valid_q;
      tag_d    = tag_q;
      data_d   = data_q;
      fill_d   = fill_q;
      rd_op_d  = rd_op_q;
      DataOut  = 16'h0000;
      Stall    = 1'b0;
      Done     = 1'b0;
      CacheHit = 1'b0;
      err      = 1'b0;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (illegal_s) begin
               err = 1'b1;
            end else if (Rd) begin
               if (line_hit_s) begin
                  DataOut  = data_q[idx_s];
                  Done     = 1'b1;
                  CacheHit = 1'b1;
               end else begin
                  Stall   = 1'b1;
                  rd_op_d = 1'b1;
                  state_d = S_RD_MISS;
               end
            end else if (Wr) begin
               Stall   = 1'b1;
               rd_op_d = 1'b0;
               state_d = S_WR_THRU;
            end else if (createdump) begin
               valid_d = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD_MISS: begin
            mem_rd = 1'b1;
            Stall  = 1'b1;
            if (mem_ready) begin
               tag_d[idx_s]   = tag_s;
               data_d[idx_s]  = mem_rdata;
               valid_d[idx_s] = 1'b1;
               fill_d         = mem_rdata;
               state_d        = S_COMPLETE;
            end else begin
               state_d = S_RD_MISS;
            end
         end
         S_WR_THRU: begin
            mem_wr = 1'b1;
            Stall  = 1'b1;
            if (mem_ready) begin
               // Write-through without allocation: only a resident line is refreshed.
               if (line_hit_s) begin
                  data_d[idx_s] = DataIn;
               end else begin
                  data_d[idx_s] = data_q[idx_s];
               end
               state_d = S_COMPLETE;
            end else begin
               state_d = S_WR_THRU;
            end
         end
         S_COMPLETE: begin
            Done    = 1'b1;
            DataOut = rd_op_q ? fill_q : 16'h0000;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, valid bits and line storage; reset wins over any pending fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         valid_q <= '0;
         fill_q  <= 16'h0000;
         rd_op_q <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
         fill_q  <= fill_d;
         rd_op_q <= rd_op_d;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [15:0] hit_count_q, hit_count_d;
   logic [15:0] miss_count_q, miss_count_d;

   // Saturating event counters; flush leaves them untouched.
   always_comb begin
      hit_count_d  = hit_count_q;
      miss_count_d = miss_count_q;
      if (legal_rd_s & line_hit_s & (hit_count_q != 16'hFFFF)) begin
         hit_count_d = hit_count_q + 16'd1;
      end else begin
         hit_count_d = hit_count_q;
      end
      if (legal_rd_s & ~line_hit_s & (miss_count_q != 16'hFFFF)) begin
         miss_count_d = miss_count_q + 16'd1;
      end else begin
         miss_count_d = miss_count_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count_q  <= 16'h0000;
         miss_count_q <= 16'h0000;
      end else begin
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`endif

endmodule
